scoreboard_stats: RTL and testbench

//  Parametrised successor to the single-bit error scoreboard. Compares a DUT result against a

---
 rtl/scoreboard_stats_pkg.sv | 13 +
 rtl/scoreboard_stats_if.sv | 34 +++
 rtl/scoreboard_stats_absdiff.sv | 52 +++++
 rtl/scoreboard_stats.sv | 124 ++++++++++++
 tb/tb_scoreboard_stats.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_stats_pkg.sv
// Shared defaults and helpers for the result-comparison statistics block.
// Imported by the interface, the absdiff stage and the top.
package scoreboard_stats_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CTR_W = 32;
  localparam int DEF_TOL   = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scoreboard_stats_if.sv
// Sample bus into the scoreboard and statistics readout back to the host.
// master drives samples/controls, slave (the scoreboard) drives the statistics.
interface scoreboard_stats_if import scoreboard_stats_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CTR_W = DEF_CTR_W
);
  logic             i_clear;
  logic             i_freeze;
  logic             i_valid;
  logic [WIDTH-1:0] i_dut;
  logic [WIDTH-1:0] i_ref;
  logic [CTR_W-1:0] o_data_ctr;
  logic [CTR_W-1:0] o_error_ctr;
  logic [WIDTH:0]   o_maxerr;
  logic [WIDTH:0]   o_minerr;
  logic [CTR_W-1:0] o_errsum;
  logic             o_err_seen;
  logic [CTR_W-1:0] o_first_idx;
  logic [WIDTH-1:0] o_first_dut;
  logic [WIDTH-1:0] o_first_ref;
  logic             o_busy;

  modport master (
    output i_clear, i_freeze, i_valid, i_dut, i_ref,
    input  o_data_ctr, o_error_ctr, o_maxerr, o_minerr, o_errsum,
           o_err_seen, o_first_idx, o_first_dut, o_first_ref, o_busy
  );

  modport slave (
    input  i_clear, i_freeze, i_valid, i_dut, i_ref,
    output o_data_ctr, o_error_ctr, o_maxerr, o_minerr, o_errsum,
           o_err_seen, o_first_idx, o_first_dut, o_first_ref, o_busy
  );
endinterface

// File: rtl/scoreboard_stats_absdiff.sv
// First stage: registers signed dut-ref difference, its magnitude and the operands.
// Latency 1 cycle; no backpressure, clear flushes the stage.
module sb_absdiff import scoreboard_stats_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_vld,
  input  logic [WIDTH-1:0]        dut,
  input  logic [WIDTH-1:0]        ref_v,
  output logic                    vld,
  output logic signed [WIDTH:0]   diff,
  output logic [WIDTH:0]          abs_v,
  output logic [WIDTH-1:0]        dut_q,
  output logic [WIDTH-1:0]        ref_q
);

  logic signed [WIDTH:0] diff_c;
  logic [WIDTH:0]        abs_c;

  // Operands are zero-extended, so |diff| never exceeds 2^WIDTH-1 and negation cannot overflow.
  always_comb begin
    diff_c = $signed({1'b0, dut}) - $signed({1'b0, ref_v});
    abs_c  = diff_c[WIDTH] ? $unsigned(-diff_c) : $unsigned(diff_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= 1'b0;
      diff  <= '0;
      abs_v <= '0;
      dut_q <= '0;
      ref_q <= '0;
    end else if (clear) begin
      vld   <= 1'b0;
      diff  <= '0;
      abs_v <= '0;
      dut_q <= '0;
      ref_q <= '0;
    end else begin
      vld <= in_vld;
      if (in_vld) begin
        diff  <= diff_c;
        abs_v <= abs_c;
        dut_q <= dut;
        ref_q <= ref_v;
      end
    end
  end

endmodule

// File: rtl/scoreboard_stats.sv
// Compares DUT vs reference results and keeps saturating error statistics plus first-mismatch capture.
// Latency 2 cycles from accepted sample to outputs; no backpressure, freeze drops samples at input.
module scoreboard_stats import scoreboard_stats_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CTR_W = DEF_CTR_W,
  parameter int TOL   = DEF_TOL
) (
  input logic               clk,
  input logic               reset,
  scoreboard_stats_if.slave sb
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [WIDTH:0]   MIN_RST = '1;
  localparam logic [WIDTH:0]   TOL_V   = (WIDTH + 1)'(TOL);
  localparam int               SUM_W   = max_int(CTR_W, WIDTH + 1) + 1;

  logic                  accept;
  logic                  s1_vld;
  logic signed [WIDTH:0] s1_diff;
  logic [WIDTH:0]        s1_abs;
  logic [WIDTH-1:0]      s1_dut;
  logic [WIDTH-1:0]      s1_ref;

  logic                  s2_vld;
  logic [CTR_W-1:0]      data_ctr;
  logic [CTR_W-1:0]      error_ctr;
  logic [WIDTH:0]        maxerr;
  logic [WIDTH:0]        minerr;
  logic [CTR_W-1:0]      errsum;
  logic                  err_seen;
  logic [CTR_W-1:0]      first_idx;
  logic [WIDTH-1:0]      first_dut;
  logic [WIDTH-1:0]      first_ref;

  logic [SUM_W-1:0]      sum_wide;
  logic [CTR_W-1:0]      sum_sat;
  logic                  mismatch;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
    return (v == CTR_MAX) ? v : v + CTR_W'(1);
  endfunction

  assign accept = sb.i_valid && !sb.i_freeze && !sb.i_clear;

  sb_absdiff #(.WIDTH(WIDTH)) u_s1 (
    .clk    (clk),
    .reset  (reset),
    .clear  (sb.i_clear),
    .in_vld (accept),
    .dut    (sb.i_dut),
    .ref_v  (sb.i_ref),
    .vld    (s1_vld),
    .diff   (s1_diff),
    .abs_v  (s1_abs),
    .dut_q  (s1_dut),
    .ref_q  (s1_ref)
  );

  // Sum is formed wide enough for either operand, then clamped to the counter width.
  always_comb begin
    sum_wide = SUM_W'(errsum) + SUM_W'(s1_abs);
    sum_sat  = (sum_wide > SUM_W'(CTR_MAX)) ? CTR_MAX : CTR_W'(sum_wide);
    mismatch = (s1_abs > TOL_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld    <= 1'b0;
      data_ctr  <= '0;
      error_ctr <= '0;
      maxerr    <= '0;
      minerr    <= MIN_RST;
      errsum    <= '0;
      err_seen  <= 1'b0;
      first_idx <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else if (sb.i_clear) begin
      s2_vld    <= 1'b0;
      data_ctr  <= '0;
      error_ctr <= '0;
      maxerr    <= '0;
      minerr    <= MIN_RST;
      errsum    <= '0;
      err_seen  <= 1'b0;
      first_idx <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        data_ctr <= sat_inc(data_ctr);
        errsum   <= sum_sat;
        if (s1_abs > maxerr)
          maxerr <= s1_abs;
        if (s1_diff != '0 && s1_abs < minerr)
          minerr <= s1_abs;
        if (mismatch) begin
          error_ctr <= sat_inc(error_ctr);
          // Only the first mismatch is captured; index is the pre-increment sample count.
          if (!err_seen) begin
            err_seen  <= 1'b1;
            first_idx <= data_ctr;
            first_dut <= s1_dut;
            first_ref <= s1_ref;
          end
        end
      end
    end
  end

  assign sb.o_data_ctr  = data_ctr;
  assign sb.o_error_ctr = error_ctr;
  assign sb.o_maxerr    = maxerr;
  assign sb.o_minerr    = minerr;
  assign sb.o_errsum    = errsum;
  assign sb.o_err_seen  = err_seen;
  assign sb.o_first_idx = first_idx;
  assign sb.o_first_dut = first_dut;
  assign sb.o_first_ref = first_ref;
  assign sb.o_busy      = s1_vld | s2_vld;

endmodule

// File: tb/tb_scoreboard_stats.sv
// Bench for scoreboard_stats: three instances (TOL=0, TOL=2, CTR_W=4) with expected-stat queues
// drained by per-instance monitors when o_busy falls or a snapshot is requested.
module tb_scoreboard_stats;

  typedef struct {
    logic [31:0] data_ctr;
    logic [31:0] error_ctr;
    logic [8:0]  maxerr;
    logic [8:0]  minerr;
    logic [31:0] errsum;
    logic        err_seen;
    logic [31:0] first_idx;
    logic [7:0]  first_dut;
    logic [7:0]  first_ref;
  } exp_t;

  logic clk;
  logic reset;
  logic [2:0] chk_req;
  int checks;
  int errors;
  exp_t q_a[$];
  exp_t q_t[$];
  exp_t q_c[$];
  logic busy_a, busy_t, busy_c;

  scoreboard_stats_if #(.WIDTH(8), .CTR_W(32)) bus_a ();
  scoreboard_stats_if #(.WIDTH(8), .CTR_W(32)) bus_t ();
  scoreboard_stats_if #(.WIDTH(8), .CTR_W(4))  bus_c ();

  scoreboard_stats #(.WIDTH(8), .CTR_W(32), .TOL(0)) dut_a (.clk(clk), .reset(reset), .sb(bus_a));
  scoreboard_stats #(.WIDTH(8), .CTR_W(32), .TOL(2)) dut_t (.clk(clk), .reset(reset), .sb(bus_t));
  scoreboard_stats #(.WIDTH(8), .CTR_W(4),  .TOL(0)) dut_c (.clk(clk), .reset(reset), .sb(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] e, input logic [8:0] mx,
                              input logic [8:0] mn, input logic [31:0] sum, input logic seen,
                              input logic [31:0] idx, input logic [7:0] fd, input logic [7:0] fr);
    exp_t x;
    x.data_ctr = d;  x.error_ctr = e; x.maxerr = mx; x.minerr = mn; x.errsum = sum;
    x.err_seen = seen; x.first_idx = idx; x.first_dut = fd; x.first_ref = fr;
    return x;
  endfunction

  function automatic exp_t rst_exp();
    return mk(0, 0, 9'h000, 9'h1FF, 0, 1'b0, 0, 8'h00, 8'h00);
  endfunction

  function automatic exp_t obs_a();
    return mk(bus_a.o_data_ctr, bus_a.o_error_ctr, bus_a.o_maxerr, bus_a.o_minerr, bus_a.o_errsum,
              bus_a.o_err_seen, bus_a.o_first_idx, bus_a.o_first_dut, bus_a.o_first_ref);
  endfunction

  function automatic exp_t obs_t();
    return mk(bus_t.o_data_ctr, bus_t.o_error_ctr, bus_t.o_maxerr, bus_t.o_minerr, bus_t.o_errsum,
              bus_t.o_err_seen, bus_t.o_first_idx, bus_t.o_first_dut, bus_t.o_first_ref);
  endfunction

  function automatic exp_t obs_c();
    return mk(32'(bus_c.o_data_ctr), 32'(bus_c.o_error_ctr), bus_c.o_maxerr, bus_c.o_minerr,
              32'(bus_c.o_errsum), bus_c.o_err_seen, 32'(bus_c.o_first_idx),
              bus_c.o_first_dut, bus_c.o_first_ref);
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e, input exp_t a);
    chk(tag, "data_ctr",  a.data_ctr,       e.data_ctr);
    chk(tag, "error_ctr", a.error_ctr,      e.error_ctr);
    chk(tag, "maxerr",    32'(a.maxerr),    32'(e.maxerr));
    chk(tag, "minerr",    32'(a.minerr),    32'(e.minerr));
    chk(tag, "errsum",    a.errsum,         e.errsum);
    chk(tag, "err_seen",  32'(a.err_seen),  32'(e.err_seen));
    chk(tag, "first_idx", a.first_idx,      e.first_idx);
    chk(tag, "first_dut", 32'(a.first_dut), 32'(e.first_dut));
    chk(tag, "first_ref", 32'(a.first_ref), 32'(e.first_ref));
  endtask

  task automatic no_exp(input string tag);
    checks++;
    errors++;
    $display("FAIL %s.unexpected_drain got busy fall expected none queued", tag);
  endtask

  // Monitors: compare on a busy 1->0 transition (batch drained) or on an explicit snapshot request.
  always @(negedge clk) begin
    if ((busy_a === 1'b1 && bus_a.o_busy === 1'b0) || chk_req[0]) begin
      if (q_a.size() == 0) no_exp("a");
      else check_all("a", q_a.pop_front(), obs_a());
    end
    busy_a <= bus_a.o_busy;
  end

  always @(negedge clk) begin
    if ((busy_t === 1'b1 && bus_t.o_busy === 1'b0) || chk_req[1]) begin
      if (q_t.size() == 0) no_exp("tol");
      else check_all("tol", q_t.pop_front(), obs_t());
    end
    busy_t <= bus_t.o_busy;
  end

  always @(negedge clk) begin
    if ((busy_c === 1'b1 && bus_c.o_busy === 1'b0) || chk_req[2]) begin
      if (q_c.size() == 0) no_exp("ctr4");
      else check_all("ctr4", q_c.pop_front(), obs_c());
    end
    busy_c <= bus_c.o_busy;
  end

  task automatic drive(input int w, input logic v, input logic f, input logic c,
                       input logic [7:0] d, input logic [7:0] r);
    @(posedge clk);
    #1;
    case (w)
      0: begin bus_a.i_valid = v; bus_a.i_freeze = f; bus_a.i_clear = c; bus_a.i_dut = d; bus_a.i_ref = r; end
      1: begin bus_t.i_valid = v; bus_t.i_freeze = f; bus_t.i_clear = c; bus_t.i_dut = d; bus_t.i_ref = r; end
      default: begin bus_c.i_valid = v; bus_c.i_freeze = f; bus_c.i_clear = c; bus_c.i_dut = d; bus_c.i_ref = r; end
    endcase
  endtask

  task automatic idle(input int w, input int n);
    for (int i = 0; i < n; i++) drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic clear_a();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    idle(0, 2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_req = 3'b000;
    reset = 1'b1;
    bus_a.i_valid = 0; bus_a.i_freeze = 0; bus_a.i_clear = 0; bus_a.i_dut = 0; bus_a.i_ref = 0;
    bus_t.i_valid = 0; bus_t.i_freeze = 0; bus_t.i_clear = 0; bus_t.i_dut = 0; bus_t.i_ref = 0;
    bus_c.i_valid = 0; bus_c.i_freeze = 0; bus_c.i_clear = 0; bus_c.i_dut = 0; bus_c.i_ref = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values on all three instances
    q_a.push_back(rst_exp()); q_t.push_back(rst_exp()); q_c.push_back(rst_exp());
    @(posedge clk); #1 chk_req = 3'b111;
    @(posedge clk); #1 chk_req = 3'b000;

    // Five exact matches
    q_a.push_back(mk(5, 0, 9'h000, 9'h1FF, 0, 1'b0, 0, 8'h00, 8'h00));
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40);
    idle(0, 4);
    clear_a();

    // Three mismatches: |err| 3, 255, 1
    q_a.push_back(mk(3, 3, 9'h0FF, 9'h001, 259, 1'b1, 0, 8'h10, 8'h13));
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h13);
    drive(0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h04);
    idle(0, 4);
    clear_a();

    // Freeze window containing a mismatch, then three accepted matches
    q_a.push_back(mk(3, 0, 9'h000, 9'h1FF, 0, 1'b0, 0, 8'h00, 8'h00));
    drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h21);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h33);
    idle(0, 4);
    clear_a();

    // Clear one cycle after an accepted mismatch, with another sample presented during clear
    q_a.push_back(rst_exp());
    drive(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h09);
    drive(0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00);
    idle(0, 3);

    // Async reset mid-stream
    q_a.push_back(rst_exp());
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(posedge clk); #1 reset = 1'b1;
    idle(0, 2);
    @(posedge clk); #1 reset = 1'b0;
    idle(0, 1);

    // Single sample after reset release
    q_a.push_back(mk(1, 1, 9'h002, 9'h002, 2, 1'b1, 0, 8'h80, 8'h7E));
    drive(0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h7E);
    idle(0, 4);

    // TOL=2: |err| 1, 2, 3 -> only the last is a mismatch
    q_t.push_back(mk(3, 1, 9'h003, 9'h001, 6, 1'b1, 2, 8'h50, 8'h4D));
    drive(1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h10);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h22);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h50, 8'h4D);
    idle(1, 4);

    // CTR_W=4: 20 mismatches of |err| 2 -> counters and sum hold at 15
    q_c.push_back(mk(15, 15, 9'h002, 9'h002, 15, 1'b1, 0, 8'h02, 8'h00));
    for (int i = 0; i < 20; i++) drive(2, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    idle(2, 4);

    for (int i = 0; i < 50 && (q_a.size() + q_t.size() + q_c.size()) > 0; i++) @(posedge clk);
    while (q_a.size() > 0) begin
      void'(q_a.pop_front()); checks++; errors++;
      $display("FAIL a.pending got no drain expected busy fall");
    end
    while (q_t.size() > 0) begin
      void'(q_t.pop_front()); checks++; errors++;
      $display("FAIL tol.pending got no drain expected busy fall");
    end
    while (q_c.size() > 0) begin
      void'(q_c.pop_front()); checks++; errors++;
      $display("FAIL ctr4.pending got no drain expected busy fall");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
